// File: rtl/kitten_pkg.sv
// Shared definitions for the Kitten step sequencer.
// Contents:
//   - ST_*  : state encodings of the sequencer FSM
//   - ERR_* : sticky error codes reported on o_error
package kitten_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_PROJ = 3'd2;
  localparam logic [2:0] ST_PROJ      = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ABORT   = 2'b10;

endpackage

// File: rtl/kitten_step_sequencer_if.sv
// Host/tile signal bundle of the Kitten step sequencer.
// Inputs to the sequencer (i_*):
//   i_step_start, i_proj_done : CONTROL register levels
//   i_num_steps               : steps per batch
//   i_abort, i_clear          : single-cycle strobes
//   i_tile_step_done          : tile step-complete pulse
//   i_tile_busy               : tile busy level
// Outputs of the sequencer (o_*):
//   o_tile_start, o_tile_proj_done : one-cycle pulses to the tile
//   o_busy, o_step_done, o_error, o_step_count : status
// Modports: slave = sequencer view, master = host/tile view.
interface kitten_step_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 i_step_start;
  logic                 i_proj_done;
  logic [CNT_WIDTH-1:0] i_num_steps;
  logic                 i_abort;
  logic                 i_clear;
  logic                 i_tile_step_done;
  logic                 i_tile_busy;
  logic                 o_tile_start;
  logic                 o_tile_proj_done;
  logic                 o_busy;
  logic                 o_step_done;
  logic [1:0]           o_error;
  logic [CNT_WIDTH-1:0] o_step_count;

  modport slave (
    input  i_step_start, i_proj_done, i_num_steps, i_abort, i_clear,
           i_tile_step_done, i_tile_busy,
    output o_tile_start, o_tile_proj_done, o_busy, o_step_done, o_error,
           o_step_count
  );

  modport master (
    output i_step_start, i_proj_done, i_num_steps, i_abort, i_clear,
           i_tile_step_done, i_tile_busy,
    input  o_tile_start, o_tile_proj_done, o_busy, o_step_done, o_error,
           o_step_count
  );

endinterface

// File: rtl/kitten_rise_detect.sv
// Rising-edge detector with a registered history bit.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   d        : sampled level
//   rise     : high while d is 1 and the previous sample was 0
module kitten_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/kitten_step_sequencer.sv
// Kitten step sequencer: runs the fabric tile through a batch of LIF
// time-steps on host command, with watchdog timeout, abort and sticky status.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : host/tile bundle (slave modport), see kitten_step_sequencer_if
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | waiting for a start edge with no sticky error
// START     | o_tile_start pulse for one cycle
// WAIT_PROJ | waiting for host proj_done with tile not busy
// PROJ      | o_tile_proj_done pulse for one cycle
// RUN       | waiting for tile step_done, watchdog counting
// DONE      | batch complete, o_step_done set, back to IDLE
module kitten_step_sequencer
  import kitten_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int TO_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  kitten_step_sequencer_if.slave   bus
);

  localparam logic [TO_WIDTH-1:0]  WDOG_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic                 step_rise;
  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [CNT_WIDTH-1:0] target_q;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [TO_WIDTH-1:0]  wdog_q;
  logic                 launch;
  logic                 abort_hit;
  logic                 step_hit;
  logic                 wdog_expired;

  kitten_rise_detect u_start_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.i_step_start),
    .rise (step_rise)
  );

  always_comb begin
    cnt_inc      = (bus.o_step_count == '1) ? bus.o_step_count
                                            : bus.o_step_count + CNT_ONE;
    abort_hit    = bus.i_abort && (state_q != ST_IDLE);
    launch       = (state_q == ST_IDLE) && step_rise && (bus.o_error == ERR_NONE);
    step_hit     = (state_q == ST_RUN) && bus.i_tile_step_done && !abort_hit;
    // step_done in the expiry cycle wins over the timeout
    wdog_expired = (state_q == ST_RUN) && !bus.i_tile_step_done && !abort_hit &&
                   (wdog_q == WDOG_LAST);

    state_d = state_q;
    if (abort_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (launch) state_d = ST_START;
        ST_START:     state_d = ST_WAIT_PROJ;
        ST_WAIT_PROJ: if (bus.i_proj_done && !bus.i_tile_busy) state_d = ST_PROJ;
        ST_PROJ:      state_d = ST_RUN;
        ST_RUN: begin
          if (step_hit)          state_d = (cnt_inc == target_q) ? ST_DONE : ST_START;
          else if (wdog_expired) state_d = ST_IDLE;
        end
        ST_DONE:      state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each pulse lines up
  // exactly with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q              <= ST_IDLE;
      target_q             <= '0;
      wdog_q               <= '0;
      bus.o_tile_start     <= 1'b0;
      bus.o_tile_proj_done <= 1'b0;
      bus.o_busy           <= 1'b0;
      bus.o_step_done      <= 1'b0;
      bus.o_error          <= ERR_NONE;
      bus.o_step_count     <= '0;
    end else begin
      state_q              <= state_d;
      bus.o_tile_start     <= (state_d == ST_START);
      bus.o_tile_proj_done <= (state_d == ST_PROJ);
      bus.o_busy           <= (state_d != ST_IDLE);

      if (launch) begin
        target_q         <= (bus.i_num_steps == '0) ? CNT_ONE : bus.i_num_steps;
        bus.o_step_count <= '0;
      end else if (step_hit) begin
        bus.o_step_count <= cnt_inc;
      end

      if (state_d == ST_RUN && state_q != ST_RUN) wdog_q <= '0;
      else if (state_q == ST_RUN)                 wdog_q <= wdog_q + TO_WIDTH'(1);

      if (state_d == ST_DONE)         bus.o_step_done <= 1'b1;
      else if (launch || bus.i_clear) bus.o_step_done <= 1'b0;

      // a new error beats a coincident clear
      if (abort_hit)         bus.o_error <= ERR_ABORT;
      else if (wdog_expired) bus.o_error <= ERR_TIMEOUT;
      else if (bus.i_clear)  bus.o_error <= ERR_NONE;
    end
  end

endmodule

// File: tb/tb_kitten_step_sequencer.sv
// Directed scoreboard bench for kitten_step_sequencer (TIMEOUT_CYCLES=16).
module tb_kitten_step_sequencer;
  import kitten_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  kitten_step_sequencer_if #(.CNT_WIDTH(16)) bus();

  kitten_step_sequencer #(
    .CNT_WIDTH      (16),
    .TO_WIDTH       (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int       starts;
    int       projs;
    int       cnt;
    bit       done;
    bit [1:0] err;
  } end_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  end_t end_q[$];
  int   start_q[$];

  logic m_busy_prev = 1'b0;
  int   m_starts    = 0;
  int   m_projs     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_batch(input int starts, input int projs, input int cnt,
                            input bit done, input bit [1:0] err);
    end_t e;
    e.starts = starts; e.projs = projs; e.cnt = cnt; e.done = done; e.err = err;
    end_q.push_back(e);
    for (int i = 0; i < starts; i++) start_q.push_back(i);
  endtask

  // Monitor: pops expectations whenever the DUT pulses start or ends a batch.
  initial begin : monitor
    end_t e;
    forever begin
      @(negedge clk);
      if (bus.o_tile_start === 1'b1) begin
        m_starts++;
        if (start_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
        else check("count_at_start", bus.o_step_count, start_q.pop_front());
      end
      if (bus.o_tile_proj_done === 1'b1) m_projs++;
      if (m_busy_prev && bus.o_busy !== 1'b1) begin
        if (end_q.size() == 0) begin
          check("unexpected_batch_end", 32'd1, 32'd0);
        end else begin
          e = end_q.pop_front();
          check("batch_starts", m_starts, e.starts);
          check("batch_projs", m_projs, e.projs);
          check("batch_count", bus.o_step_count, e.cnt);
          check("batch_done", bus.o_step_done, e.done);
          check("batch_error", bus.o_error, e.err);
        end
        m_starts = 0;
        m_projs  = 0;
      end
      m_busy_prev = (bus.o_busy === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch();
    bus.i_step_start = 1'b0;
    tick(1);
    bus.i_step_start = 1'b1;
  endtask

  task automatic wait_proj();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.o_tile_proj_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("proj_pulse_seen", ok, 1'b1);
  endtask

  task automatic pulse_step_done();
    bus.i_tile_step_done = 1'b1;
    tick(1);
    bus.i_tile_step_done = 1'b0;
  endtask

  task automatic do_step(input int gap);
    wait_proj();
    repeat (gap) @(negedge clk);
    pulse_step_done();
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", ok, 1'b1);
  endtask

  task automatic pulse_clear();
    bus.i_clear = 1'b1;
    tick(1);
    bus.i_clear = 1'b0;
  endtask

  initial begin : stimulus
    rst                  = 1'b1;
    bus.i_step_start     = 1'b0;
    bus.i_proj_done      = 1'b0;
    bus.i_num_steps      = '0;
    bus.i_abort          = 1'b0;
    bus.i_clear          = 1'b0;
    bus.i_tile_step_done = 1'b0;
    bus.i_tile_busy      = 1'b0;
    tick(3);
    check("reset_outputs",
          {bus.o_tile_start, bus.o_tile_proj_done, bus.o_busy, bus.o_step_done,
           bus.o_error, bus.o_step_count}, 32'd0);
    rst = 1'b0;
    tick(2);

    // single step, with launch latency check
    bus.i_num_steps = 16'd1;
    bus.i_proj_done = 1'b1;
    push_batch(1, 1, 1, 1'b1, ERR_NONE);
    launch();
    @(posedge clk);
    @(negedge clk);
    check("start_latency", bus.o_tile_start, 1'b1);
    do_step(5);
    wait_idle();

    // step_done in IDLE is not counted
    tick(2);
    pulse_step_done();
    tick(2);
    check("idle_step_done_count", bus.o_step_count, 16'd1);
    check("idle_step_done_busy", bus.o_busy, 1'b0);
    check("idle_step_done_sticky", bus.o_step_done, 1'b1);

    // three-step batch
    bus.i_num_steps = 16'd3;
    push_batch(3, 3, 3, 1'b1, ERR_NONE);
    launch();
    for (int i = 0; i < 3; i++) begin
      wait_proj();
      check("batch_done_low", bus.o_step_done, 1'b0);
      check("batch_count_mid", bus.o_step_count, i);
      if (i == 1) bus.i_num_steps = 16'd1;
      repeat (2) @(negedge clk);
      pulse_step_done();
    end
    wait_idle();

    // zero steps behaves as one
    bus.i_num_steps = 16'd0;
    push_batch(1, 1, 1, 1'b1, ERR_NONE);
    launch();
    do_step(1);
    wait_idle();

    // step_done in the watchdog expiry cycle wins
    bus.i_num_steps = 16'd1;
    push_batch(1, 1, 1, 1'b1, ERR_NONE);
    launch();
    wait_proj();
    repeat (16) @(negedge clk);
    pulse_step_done();
    wait_idle();
    check("race_no_error", bus.o_error, ERR_NONE);

    // timeout after exactly 16 RUN cycles
    push_batch(1, 1, 0, 1'b0, ERR_TIMEOUT);
    launch();
    wait_proj();
    repeat (16) @(negedge clk);
    check("timeout_busy_before", bus.o_busy, 1'b1);
    @(negedge clk);
    check("timeout_busy_after", bus.o_busy, 1'b0);
    check("timeout_error", bus.o_error, ERR_TIMEOUT);
    launch();
    tick(4);
    check("edge_ignored_on_error", bus.o_busy, 1'b0);
    pulse_clear();
    check("clear_error", bus.o_error, ERR_NONE);
    check("clear_keeps_count", bus.o_step_count, 16'd0);
    push_batch(1, 1, 1, 1'b1, ERR_NONE);
    launch();
    do_step(3);
    wait_idle();

    // abort in WAIT_PROJ
    bus.i_proj_done = 1'b0;
    push_batch(1, 0, 0, 1'b0, ERR_ABORT);
    launch();
    tick(3);
    bus.i_abort = 1'b1;
    tick(1);
    bus.i_abort = 1'b0;
    check("abort_busy", bus.o_busy, 1'b0);
    check("abort_error", bus.o_error, ERR_ABORT);
    bus.i_proj_done = 1'b1;
    tick(4);
    check("abort_no_proj", bus.o_tile_proj_done, 1'b0);

    // abort and clear together: error wins
    pulse_clear();
    bus.i_proj_done = 1'b0;
    push_batch(1, 0, 0, 1'b0, ERR_ABORT);
    launch();
    tick(3);
    bus.i_abort = 1'b1;
    bus.i_clear = 1'b1;
    tick(1);
    bus.i_abort = 1'b0;
    bus.i_clear = 1'b0;
    check("abort_clear_error", bus.o_error, ERR_ABORT);
    pulse_clear();
    check("clear_after_abort", bus.o_error, ERR_NONE);

    // async reset mid-RUN
    bus.i_proj_done = 1'b1;
    bus.i_num_steps = 16'd2;
    push_batch(1, 1, 0, 1'b0, ERR_NONE);
    launch();
    wait_proj();
    tick(3);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_run",
          {bus.o_tile_start, bus.o_tile_proj_done, bus.o_busy, bus.o_step_done,
           bus.o_error, bus.o_step_count}, 32'd0);
    bus.i_step_start = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("after_reset_idle", bus.o_busy, 1'b0);

    tick(10);
    check("end_queue_empty", end_q.size(), 0);
    check("start_queue_empty", start_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : time_limit
    #200000;
    $display("FAIL time_limit: bench still running at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/kitten_step_sequencer.md
Name: kitten_step_sequencer

Overview:
- Sequences the Kitten fabric tile through one or more LIF time-steps on host command.
- Host side: CONTROL-register levels (step_start, proj_done), a step-count value and a clear strobe from the AXI-Lite register block.
- Tile side: produces single-cycle start/proj_done pulses and consumes tile step_done/busy.
- Sits between the register block and kitten_fabric_tile; adds batch stepping, a watchdog timeout, abort and sticky status.

Parameters:
CNT_WIDTH, 16, width of step-count input and completed-step counter
TO_WIDTH, 16, width of watchdog counter
TIMEOUT_CYCLES, 65535, max cycles in RUN before timeout (must be < 2**TO_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_step_start  in  1  host start level (CONTROL bit0); rising edge launches a batch
i_proj_done  in  1  host projection-ready level (CONTROL bit1)
i_num_steps  in  CNT_WIDTH  steps per batch, latched at launch; 0 treated as 1
i_abort  in  1  single-cycle abort strobe
i_clear  in  1  single-cycle strobe clearing sticky status
i_tile_step_done  in  1  tile step-complete pulse
i_tile_busy  in  1  tile busy level
o_tile_start  out  1  one-cycle step start pulse to tile
o_tile_proj_done  out  1  one-cycle projection-done pulse to tile
o_busy  out  1  high in any state other than IDLE
o_step_done  out  1  sticky: batch completed
o_error  out  2  sticky: 00 none, 01 timeout, 10 abort
o_step_count  out  CNT_WIDTH  steps completed in current/last batch

Behaviour:
- Reset (async): state IDLE; all outputs 0; edge-detect history 0; latched step target 0; watchdog 0.
- All outputs are registered. A rising edge of i_step_start is a sample of 1 where the previous sample was 0.
- IDLE:
  - Rising edge of i_step_start with o_error==00 → START.
  - On entry to START: latch max(i_num_steps,1); clear o_step_count and o_step_done.
  - Edges arriving while o_error!=00 are ignored.
- START (1 cycle): o_tile_start=1 for exactly this cycle → WAIT_PROJ.
- WAIT_PROJ: on the first cycle with i_proj_done==1 and i_tile_busy==0 → PROJ. No timeout in this state.
- PROJ (1 cycle): o_tile_proj_done=1 → RUN. Watchdog is cleared on entry to RUN.
- RUN:
  - i_tile_step_done==1: o_step_count+=1. If new count == target → DONE; else → START, with no gap cycle besides START itself.
  - Watchdog increments each RUN cycle. On reaching TIMEOUT_CYCLES without step_done → IDLE with o_error=01.
  - If step_done and watchdog expiry occur in the same cycle, step_done wins.
- DONE (1 cycle): o_step_done=1 (sticky) → IDLE.
- Latency: i_step_start edge sampled at edge k → o_tile_start high in cycle k+1 → o_tile_proj_done no earlier than cycle k+3.
- i_abort:
  - In any non-IDLE state → IDLE next cycle with o_error=10, and no further tile pulses.
  - Takes priority over every other event in that cycle. Ignored in IDLE.
- i_clear: clears o_error and o_step_done. o_step_count holds its value. If i_clear coincides with abort or timeout, the error is set (error wins).
- i_tile_step_done outside RUN is ignored; it is not counted.
- o_step_count saturates at all-ones; it cannot wrap because target ≤ all-ones.
- Changing i_num_steps mid-batch has no effect.
- Reset asserted mid-batch returns to IDLE immediately with no pulse glitch.

Decomposition:
- Shared package kitten_pkg holds:
  - state enum: IDLE, START, WAIT_PROJ, PROJ, RUN, DONE
  - error codes: ERR_NONE=2'b00, ERR_TIMEOUT=2'b01, ERR_ABORT=2'b10
- One sub-module: kitten_rise_detect, a registered rising-edge detector with async reset, used for i_step_start.

Test Plan:
- Single step: i_num_steps=1; raise i_step_start; hold i_proj_done=1; tile step_done 5 cycles after proj pulse → exactly one o_tile_start and one o_tile_proj_done; o_step_count=1; o_step_done=1; o_busy back to 0.
- Batch: i_num_steps=3 with proj_done held high → three start/proj pulse pairs; o_step_count goes 1,2,3; o_step_done set once, after the 3rd step.
- num_steps=0 → behaves as 1 step; o_step_count=1.
- Timeout: TIMEOUT_CYCLES=16, no step_done → o_error=01 after 16 RUN cycles; next start edge ignored; i_clear, then new edge → batch runs.
- Abort in WAIT_PROJ, then i_proj_done raised → no o_tile_proj_done; o_error=10; o_busy=0 next cycle. Also check the abort+clear same-cycle case → o_error=10.
- Race and spurious inputs:
  - step_done and watchdog expiry in the same cycle → step counted, no error.
  - step_done pulsed in IDLE → o_step_count unchanged.
  - async rst mid-RUN → all outputs 0 immediately.
